fifo_flag_sync: RTL and testbench

//  Synchronous FIFO pointer/flag controller, single clock domain; successor to the async direction-latch flag block.

---
 rtl/fifo_flag_sync_pkg.sv | 27 ++
 rtl/fifo_flag_sync_ptr.sv | 48 ++++
 rtl/fifo_flag_sync.sv | 138 +++++++++++++
 tb/tb_fifo_flag_sync.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_flag_sync_pkg.sv
// Shared definitions for the synchronous FIFO flag controller.
// Holds the bit positions of the six-bit status word
// {underflow, overflow, almost_empty, almost_full, empty, full}.
// Also holds constant functions that turn the address width into:
//   - the pointer width (address bits plus one wrap bit), and
//   - the FIFO size (2^depth entries).
package fifo_flag_sync_pkg;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_AF        = 2;
    localparam int STAT_AE        = 3;
    localparam int STAT_OVERFLOW  = 4;
    localparam int STAT_UNDERFLOW = 5;
    localparam int STAT_W         = 6;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return depth + 1;
    endfunction

    // Number of storage entries addressed by 'depth' address bits.
    function automatic int fifo_size(input int depth);
        return 32'sd1 << depth;
    endfunction

endpackage

// File: rtl/fifo_flag_sync_ptr.sv
// fifo_ptr: W-bit incrementing FIFO pointer.
// The pointer wraps modulo 2^W.
// Ports:
//   clock      rising-edge clock
//   reset_n    synchronous active-low reset (pointer -> 0)
//   clr_i      synchronous clear (pointer -> 0), wins over en_i
//   en_i       advance pointer by one
//   ptr_o      registered pointer value
//   ptr_nxt_o  value the pointer takes at the next edge (ignores reset)
module fifo_ptr #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] ptr_o,
    output logic [W-1:0] ptr_nxt_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // Next-pointer selection: clear beats increment.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (en_i) begin
            ptr_d = ptr_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o     = ptr_q;
    assign ptr_nxt_o = ptr_d;

endmodule

// File: rtl/fifo_flag_sync.sv
// fifo_flag_sync: single-clock FIFO pointer and flag controller.
// Drives the write/read addresses of a 2^depth-entry dual-port RAM.
// Produces registered full/empty, almost-full/empty, fill level and sticky errors.
// Ports:
//   clock, reset_n           clock and synchronous active-low reset
//   wr_en, rd_en             producer / consumer requests
//   flush                    synchronous pointer clear (sticky errors kept)
//   clr_err                  clears sticky overflow/underflow
//   af_level, ae_level       almost-full / almost-empty thresholds in entries
//   wr_address, rd_address   RAM addresses, valid with wr_ack / rd_ack
//   wr_ack, rd_ack           combinational accept strobes
//   full, empty              registered occupancy flags
//   almost_full              registered, count >= af_level
//   almost_empty             registered, count <= ae_level
//   count                    registered fill level
//   overflow, underflow      sticky request-while-full / request-while-empty
module fifo_flag_sync
    import fifo_flag_sync_pkg::*;
#(
    parameter int depth      = 8,
    parameter int af_default = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic             flush,
    input  logic             clr_err,
    input  logic [depth:0]   af_level,
    input  logic [depth:0]   ae_level,
    output logic [depth-1:0] wr_address,
    output logic [depth-1:0] rd_address,
    output logic             wr_ack,
    output logic             rd_ack,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [depth:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int PTR_W     = ptr_width(depth);
    localparam int FIFO_SIZE = fifo_size(depth);

    // With no load strobe the af_level port is always authoritative.
    // The default level only decides whether almost_full is high out of reset.
    // It is high only for a zero level, and a zero default maps to FIFO_SIZE-1.
    localparam int AF_RST_LEVEL = (af_default == 0) ? (FIFO_SIZE - 1) : af_default;
    localparam bit AF_RST_HIGH  = (AF_RST_LEVEL == 0);

    localparam logic [STAT_W-1:0] STATUS_RST =
        (6'(1'b1) << STAT_EMPTY) |
        (6'(1'b1) << STAT_AE)    |
        (6'(AF_RST_HIGH) << STAT_AF);

    logic [PTR_W-1:0]  wr_ptr_s;
    logic [PTR_W-1:0]  rd_ptr_s;
    logic [PTR_W-1:0]  wr_nxt_s;
    logic [PTR_W-1:0]  rd_nxt_s;
    logic [PTR_W-1:0]  cnt_nxt_s;
    logic [STAT_W-1:0] status_d;
    logic [STAT_W-1:0] status_q;
    logic [PTR_W-1:0]  count_d;
    logic [PTR_W-1:0]  count_q;
    logic              wr_ack_s;
    logic              rd_ack_s;

    // Acks use registered flags, so a write can never pass through while full.
    // Reset and flush both suppress acceptance in their cycle.
    assign wr_ack_s = wr_en & ~status_q[STAT_FULL]  & reset_n & ~flush;
    assign rd_ack_s = rd_en & ~status_q[STAT_EMPTY] & reset_n & ~flush;

    fifo_ptr #(.W(PTR_W)) u_wr_ptr (
        .clock     (clock),
        .reset_n   (reset_n),
        .clr_i     (flush),
        .en_i      (wr_ack_s),
        .ptr_o     (wr_ptr_s),
        .ptr_nxt_o (wr_nxt_s)
    );

    fifo_ptr #(.W(PTR_W)) u_rd_ptr (
        .clock     (clock),
        .reset_n   (reset_n),
        .clr_i     (flush),
        .en_i      (rd_ack_s),
        .ptr_o     (rd_ptr_s),
        .ptr_nxt_o (rd_nxt_s)
    );

    // The modular pointer difference is the fill level.
    // The wrap bit makes 0 and FIFO_SIZE distinguishable.
    assign cnt_nxt_s = wr_nxt_s - rd_nxt_s;

    // Next flags, count and sticky errors, all derived from the next pointers.
    always_comb begin
        status_d = status_q;
        count_d  = cnt_nxt_s;

        status_d[STAT_FULL]  = (wr_nxt_s[PTR_W-1] != rd_nxt_s[PTR_W-1]) &&
                               (wr_nxt_s[PTR_W-2:0] == rd_nxt_s[PTR_W-2:0]);
        status_d[STAT_EMPTY] = (wr_nxt_s == rd_nxt_s);
        status_d[STAT_AF]    = (cnt_nxt_s >= af_level);
        status_d[STAT_AE]    = (cnt_nxt_s <= ae_level);

        // A new error event beats a simultaneous clear.
        status_d[STAT_OVERFLOW]  = (wr_en & status_q[STAT_FULL]) |
                                   (status_q[STAT_OVERFLOW] & ~clr_err);
        status_d[STAT_UNDERFLOW] = (rd_en & status_q[STAT_EMPTY]) |
                                   (status_q[STAT_UNDERFLOW] & ~clr_err);
    end

    // Status word and count registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            status_q <= STATUS_RST;
            count_q  <= '0;
        end else begin
            status_q <= status_d;
            count_q  <= count_d;
        end
    end

    assign wr_address   = wr_ptr_s[PTR_W-2:0];
    assign rd_address   = rd_ptr_s[PTR_W-2:0];
    assign wr_ack       = wr_ack_s;
    assign rd_ack       = rd_ack_s;
    assign full         = status_q[STAT_FULL];
    assign empty        = status_q[STAT_EMPTY];
    assign almost_full  = status_q[STAT_AF];
    assign almost_empty = status_q[STAT_AE];
    assign count        = count_q;
    assign overflow     = status_q[STAT_OVERFLOW];
    assign underflow    = status_q[STAT_UNDERFLOW];

endmodule

// File: tb/tb_fifo_flag_sync.sv
// Self-checking bench for fifo_flag_sync with depth=3 (8 entries).
// The reference model tracks an integer fill level and a queue of the RAM addresses written so far.
// Each read must present the oldest address still held in that queue.
module tb_fifo_flag_sync;

    localparam int D    = 3;
    localparam int SIZE = 8;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           wr_en = 1'b0;
    logic           rd_en = 1'b0;
    logic           flush = 1'b0;
    logic           clr_err = 1'b0;
    logic [D:0]     af_level = 4'd6;
    logic [D:0]     ae_level = 4'd1;
    logic [D-1:0]   wr_address;
    logic [D-1:0]   rd_address;
    logic           wr_ack;
    logic           rd_ack;
    logic           full;
    logic           empty;
    logic           almost_full;
    logic           almost_empty;
    logic [D:0]     count;
    logic           overflow;
    logic           underflow;

    fifo_flag_sync #(.depth(D), .af_default(0)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .flush        (flush),
        .clr_err      (clr_err),
        .af_level     (af_level),
        .ae_level     (ae_level),
        .wr_address   (wr_address),
        .rd_address   (rd_address),
        .wr_ack       (wr_ack),
        .rd_ack       (rd_ack),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_cnt = 0;
    int m_wa  = 0;
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;
    int m_af  = 6;
    int m_ae  = 1;
    int addr_q[$];

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Run one clock cycle and check both the accept strobes and the registered results.
    task automatic step(input bit rst_n_v, input bit fl, input bit wr, input bit rd, input bit clr);
        bit ewa;
        bit era;
        bit was_full;
        bit was_empty;
        @(negedge clock);
        reset_n  = rst_n_v;
        flush    = fl;
        wr_en    = wr;
        rd_en    = rd;
        clr_err  = clr;
        af_level = 4'(m_af);
        ae_level = 4'(m_ae);
        #1;
        was_full  = (m_cnt == SIZE);
        was_empty = (m_cnt == 0);
        ewa = rst_n_v && !fl && wr && !was_full;
        era = rst_n_v && !fl && rd && !was_empty;
        check_val("wr_ack", int'(wr_ack), int'(ewa));
        check_val("rd_ack", int'(rd_ack), int'(era));
        if (ewa) check_val("wr_address", int'(wr_address), m_wa);
        if (era) check_val("rd_address", int'(rd_address), addr_q[0]);
        @(posedge clock);
        if (!rst_n_v) begin
            m_cnt = 0; m_wa = 0; m_ovf = 1'b0; m_unf = 1'b0;
            addr_q.delete();
        end else begin
            m_ovf = (wr && was_full)  || (m_ovf && !clr);
            m_unf = (rd && was_empty) || (m_unf && !clr);
            if (fl) begin
                m_cnt = 0; m_wa = 0;
                addr_q.delete();
            end else begin
                if (era) begin
                    void'(addr_q.pop_front());
                    m_cnt--;
                end
                if (ewa) begin
                    addr_q.push_back(m_wa);
                    m_wa = (m_wa + 1) % SIZE;
                    m_cnt++;
                end
            end
        end
        #1;
        check_val("count", int'(count), m_cnt);
        check_val("full", int'(full), int'(m_cnt == SIZE));
        check_val("empty", int'(empty), int'(m_cnt == 0));
        // Out of reset the flags are fixed rather than computed from the levels.
        check_val("almost_full", int'(almost_full), rst_n_v ? int'(m_cnt >= m_af) : 0);
        check_val("almost_empty", int'(almost_empty), rst_n_v ? int'(m_cnt <= m_ae) : 1);
        check_val("overflow", int'(overflow), int'(m_ovf));
        check_val("underflow", int'(underflow), int'(m_unf));
    endtask

    initial begin
        // Reset, then idle
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Read while empty raises underflow
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        // 9 writes: fills at 8, ninth refused and sets overflow
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        // Full with both requests: read only
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        // Drain completely
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        // Empty with both requests: write only
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        // Interleaved write/read: pointers cross the wrap boundary
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        // Count 4, then simultaneous traffic for 10 cycles
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        // Count 5, flush with a write pending; overflow set earlier is kept
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Mid-fill reset
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        // Threshold corners: af=0 forces almost_full, ae>=8 forces almost_empty
        m_af = 0; m_ae = 8;
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        m_af = 6; m_ae = 1;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        // Randomized traffic with occasional level changes, flushes and resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                m_af = $urandom_range(0, 15);
                m_ae = $urandom_range(0, 15);
            end
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 99) < 55),
                 ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 15) == 0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
